// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared pipeline constants for the hazard scoreboard
package mips_pkg;

  localparam int NREG  = 32;
  localparam int LAT_W = 3;
  localparam int CNT_W = 32;

  localparam logic [LAT_W-1:0] LAT_ALU  = 3'd0;
  localparam logic [LAT_W-1:0] LAT_LOAD = 3'd1;
  localparam logic [LAT_W-1:0] LAT_MUL  = 3'd4;
  localparam logic [LAT_W-1:0] LAT_DIV  = 3'd7;

  localparam logic [4:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/sb_entry.sv
// rtl/sb_entry.sv - one per-register countdown cell of the hazard scoreboard
module sb_entry #(
  parameter int LAT_W = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             dec,
  input  logic [LAT_W-1:0] lat,
  output logic [LAT_W-1:0] cnt,
  output logic             nz
);

  // A new issue reloads the latency and wins over the decrement; otherwise count down to zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= lat;
    end else if (dec && (cnt != '0)) begin
      cnt <= cnt - {{(LAT_W-1){1'b0}}, 1'b1};
    end
  end

  assign nz = (cnt != '0);

endmodule

// File: rtl/hazard_scoreboard.sv
// rtl/hazard_scoreboard.sv - ID-stage RAW/WAW stall detection from per-register countdowns
module hazard_scoreboard #(
  parameter int NREG  = mips_pkg::NREG,
  parameter int LAT_W = mips_pkg::LAT_W,
  parameter int CNT_W = mips_pkg::CNT_W
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             hold_i,
  input  logic             flush_i,
  input  logic [4:0]       ID_rs_i,
  input  logic [4:0]       ID_rt_i,
  input  logic             ID_rs_use_i,
  input  logic             ID_rt_use_i,
  input  logic             ID_RegWrite_i,
  input  logic [4:0]       ID_dest_i,
  input  logic [LAT_W-1:0] ID_lat_i,
  output logic             stall_o,
  output logic             waw_o,
  output logic             busy_o,
  output logic [CNT_W-1:0] stall_cnt_o
);

  import mips_pkg::REG_ZERO;

  logic [LAT_W-1:0] cnt_arr [NREG];
  logic [NREG-1:0]  nz;
  logic             raw_rs;
  logic             raw_rt;
  logic             issue;

  // r0 is hardwired: always ready, never busy.
  assign cnt_arr[0] = '0;
  assign nz[0]      = 1'b0;

  for (genvar r = 1; r < NREG; r++) begin : g_entry
    logic load;
    assign load = issue && ID_RegWrite_i && (ID_dest_i == 5'(r));
    sb_entry #(.LAT_W(LAT_W)) u_entry (
      .clk   (clk_i),
      .rst_n (rst_n_i),
      .load  (load),
      .dec   (!hold_i),
      .lat   (ID_lat_i),
      .cnt   (cnt_arr[r]),
      .nz    (nz[r])
    );
  end

  // Hazard terms use the pre-edge counts, so a register that is both source and dest sees its old value.
  always_comb begin
    raw_rs  = ID_rs_use_i && (ID_rs_i != REG_ZERO) && (cnt_arr[ID_rs_i] != '0);
    raw_rt  = ID_rt_use_i && (ID_rt_i != REG_ZERO) && (cnt_arr[ID_rt_i] != '0);
    waw_o   = ID_RegWrite_i && (ID_dest_i != REG_ZERO) && (cnt_arr[ID_dest_i] > ID_lat_i);
    stall_o = !flush_i && (raw_rs || raw_rt || waw_o);
    issue   = !hold_i && !flush_i && !stall_o;
    busy_o  = |nz;
  end

  // Performance counter: counts edges that actually hold the pipeline, saturating at all-ones.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      stall_cnt_o <= '0;
    end else if (stall_o && !hold_i && (stall_cnt_o != {CNT_W{1'b1}})) begin
      stall_cnt_o <= stall_cnt_o + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

endmodule
